// File: rtl/enc_8b10b_if.sv
// Symbol bus between framer, 8b/10b encoder and serializer.
// The slave view belongs to the encoder; the master view drives it.
interface enc_8b10b_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_is_k;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_code;
    logic       out_rd;
    logic       code_err;

    modport slave (
        input  in_valid, in_data, in_is_k, out_ready,
        output in_ready, out_valid, out_code, out_rd, code_err
    );

    modport master (
        output in_valid, in_data, in_is_k, out_ready,
        input  in_ready, out_valid, out_code, out_rd, code_err
    );
endinterface

// File: rtl/enc_8b10b.sv
// Registered 8b/10b encoder with one pipeline stage and running-disparity tracking.
// Optional macro ENC8B10B_KCHECK_EN: illegal control bytes become K28.5 and raise code_err.
module enc_8b10b #(
    parameter logic RD_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    enc_8b10b_if.slave    bus
);

    // RD- form of the 5b/6b sub-block (abcdei)
    function automatic logic [5:0] f_6b(input logic [4:0] x);
        case (x)
            5'd0:    f_6b = 6'b100111;
            5'd1:    f_6b = 6'b011101;
            5'd2:    f_6b = 6'b101101;
            5'd3:    f_6b = 6'b110001;
            5'd4:    f_6b = 6'b110101;
            5'd5:    f_6b = 6'b101001;
            5'd6:    f_6b = 6'b011001;
            5'd7:    f_6b = 6'b111000;
            5'd8:    f_6b = 6'b111001;
            5'd9:    f_6b = 6'b100101;
            5'd10:   f_6b = 6'b010101;
            5'd11:   f_6b = 6'b110100;
            5'd12:   f_6b = 6'b001101;
            5'd13:   f_6b = 6'b101100;
            5'd14:   f_6b = 6'b011100;
            5'd15:   f_6b = 6'b010111;
            5'd16:   f_6b = 6'b011011;
            5'd17:   f_6b = 6'b100011;
            5'd18:   f_6b = 6'b010011;
            5'd19:   f_6b = 6'b110010;
            5'd20:   f_6b = 6'b001011;
            5'd21:   f_6b = 6'b101010;
            5'd22:   f_6b = 6'b011010;
            5'd23:   f_6b = 6'b111010;
            5'd24:   f_6b = 6'b110011;
            5'd25:   f_6b = 6'b100110;
            5'd26:   f_6b = 6'b010110;
            5'd27:   f_6b = 6'b110110;
            5'd28:   f_6b = 6'b001110;
            5'd29:   f_6b = 6'b101110;
            5'd30:   f_6b = 6'b011110;
            5'd31:   f_6b = 6'b101011;
            default: f_6b = 6'b000000;
        endcase
    endfunction

    // RD- form of the 3b/4b sub-block (fghj); alt selects A7 over P7
    function automatic logic [3:0] f_4b(input logic [2:0] y, input logic alt);
        case (y)
            3'd0:    f_4b = 4'b1011;
            3'd1:    f_4b = 4'b1001;
            3'd2:    f_4b = 4'b0101;
            3'd3:    f_4b = 4'b1100;
            3'd4:    f_4b = 4'b1101;
            3'd5:    f_4b = 4'b1010;
            3'd6:    f_4b = 4'b0110;
            3'd7:    f_4b = alt ? 4'b0111 : 4'b1110;
            default: f_4b = 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] f_ones6(input logic [5:0] v);
        f_ones6 = 3'd0;
        for (int i = 0; i < 6; i++) begin
            f_ones6 = f_ones6 + {2'b00, v[i]};
        end
    endfunction

    logic       w_in_xfer;
    logic       w_k_legal;
    logic [7:0] w_sym;
    logic       w_k;
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k28;
    logic [5:0] w_6b_raw;
    logic       w_6b_unbal;
    logic [5:0] w_6b;
    logic       w_rd6;
    logic       w_alt;
    logic [3:0] w_4b_raw;
    logic       w_4b_unbal;
    logic       w_4b_inv;
    logic [3:0] w_4b;
    logic       w_rd_next;

    logic       r_out_valid;
    logic [9:0] r_out_code;
    logic       r_rd;

    assign w_in_xfer = bus.in_valid && bus.in_ready;

    // K behaviour is tied to the legal shapes (K28.y, K23/27/29/30.7), so other K bytes fall through as D
    assign w_k_legal = bus.in_is_k &&
                       ((bus.in_data[4:0] == 5'd28) ||
                        ((bus.in_data[7:5] == 3'd7) &&
                         ((bus.in_data[4:0] == 5'd23) || (bus.in_data[4:0] == 5'd27) ||
                          (bus.in_data[4:0] == 5'd29) || (bus.in_data[4:0] == 5'd30))));

`ifdef ENC8B10B_KCHECK_EN
    logic w_bad_k;
    logic r_code_err;

    assign w_bad_k = bus.in_is_k && !w_k_legal;
    assign w_sym   = w_bad_k ? 8'hBC : bus.in_data;
    assign w_k     = bus.in_is_k;

    // Error flag shares the lifetime of the code it accompanies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_err <= 1'b0;
        end else if (w_in_xfer) begin
            r_code_err <= w_bad_k;
        end else begin
            r_code_err <= r_code_err;
        end
    end

    assign bus.code_err = r_code_err;
`else
    assign w_sym        = bus.in_data;
    assign w_k          = w_k_legal;
    assign bus.code_err = 1'b0;
`endif

    // Two-stage encode: 6b sub-block sets the RD seen by the 4b sub-block
    always_comb begin
        w_x        = w_sym[4:0];
        w_y        = w_sym[7:5];
        w_k28      = w_k && (w_x == 5'd28);
        w_6b_raw   = w_k28 ? 6'b001111 : f_6b(w_x);
        w_6b_unbal = (f_ones6(w_6b_raw) != 3'd3);
        w_6b       = (r_rd && (w_6b_unbal || (w_x == 5'd7))) ? ~w_6b_raw : w_6b_raw;
        w_rd6      = r_rd ^ w_6b_unbal;
        w_alt      = w_k ||
                     (!w_rd6 && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                     ( w_rd6 && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14)));
        w_4b_raw   = f_4b(w_y, w_alt);
        w_4b_unbal = (f_ones6({2'b00, w_4b_raw}) != 3'd2);
        // Neutral K28 fghj patterns are the inverse polarity of their D counterparts
        if (w_k28 && !w_4b_unbal && (w_y != 3'd3)) begin
            w_4b_inv = !w_rd6;
        end else begin
            w_4b_inv = w_rd6 && (w_4b_unbal || (w_y == 3'd3));
        end
        w_4b       = w_4b_inv ? ~w_4b_raw : w_4b_raw;
        w_rd_next  = w_rd6 ^ w_4b_unbal;
    end

    // Output stage and running disparity; a stalled beat holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_code  <= 10'd0;
            r_rd        <= RD_INIT;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_code  <= {w_6b, w_4b};
            r_rd        <= w_rd_next;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_code  <= r_out_code;
            r_rd        <= r_rd;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_code  <= r_out_code;
            r_rd        <= r_rd;
        end
    end

    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_out_code;
    assign bus.out_rd    = r_rd;

endmodule

// File: tb/tb_enc_8b10b.sv
// Scoreboard bench for enc_8b10b: expected codes are queued on acceptance
// and compared as each output beat is taken by the serializer side.
module tb_enc_8b10b;

    typedef struct packed {
        logic [9:0] code;
        logic       rd;
        logic       err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t mon_e;

    enc_8b10b_if bus();

    enc_8b10b #(.RD_INIT(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output monitor: a beat is transferred at the next rising edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got code=%b rd=%b", bus.out_code, bus.out_rd);
            end else begin
                mon_e = q.pop_front();
                if ({bus.out_code, bus.out_rd, bus.code_err} !== mon_e) begin
                    failures++;
                    $display("FAIL scoreboard got code=%b rd=%b err=%b exp code=%b rd=%b err=%b",
                             bus.out_code, bus.out_rd, bus.code_err, mon_e.code, mon_e.rd, mon_e.err);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic k, input logic [9:0] c,
                        input logic r, input logic e);
        logic acc;
        int   n;
        exp_t x;
        acc = 1'b0;
        n   = 0;
        bus.in_data  = d;
        bus.in_is_k  = k;
        bus.in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got in_ready=0 exp in_ready=1 data=%h", d);
        end else begin
            x.code = c;
            x.rd   = r;
            x.err  = e;
            q.push_back(x);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d exp pending=0", q.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_is_k   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        checks++;
        if (bus.out_code !== 10'd0) begin failures++; $display("FAIL rst_out_code got %b exp 0", bus.out_code); end
        checks++;
        if (bus.out_rd !== 1'b0) begin failures++; $display("FAIL rst_out_rd got %b exp 0", bus.out_rd); end
        checks++;
        if (bus.code_err !== 1'b0) begin failures++; $display("FAIL rst_code_err got %b exp 0", bus.code_err); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        send(8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 10'b0011111010) begin
            failures++;
            $display("FAIL latency_first got v=%b code=%b exp v=1 code=0011111010", bus.out_valid, bus.out_code);
        end
        send(8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);
        checks++;
        if (bus.out_code !== 10'b1100000101) begin
            failures++;
            $display("FAIL latency_second got code=%b exp 1100000101", bus.out_code);
        end
        drain();
    endtask

    task automatic test_neutral();
        send(8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0);
        send(8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
        send(8'hB5, 1'b0, 10'b1010101010, 1'b1, 1'b0);
        send(8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_data();
        send(8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);
        send(8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0);
        drain();
    endtask

    // Starts at RD+ left by D17.7
    task automatic test_stall();
        exp_t x;
        bus.out_ready = 1'b0;
        bus.in_data   = 8'h23;
        bus.in_is_k   = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        x.code = 10'b1100011001; x.rd = 1'b1; x.err = 1'b0;
        q.push_back(x);
        bus.in_data = 8'h44;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got %b exp 0", bus.in_ready); end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_code !== 10'b1100011001 || bus.out_rd !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold got v=%b code=%b rd=%b exp v=1 code=1100011001 rd=1",
                         bus.out_valid, bus.out_code, bus.out_rd);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        x.code = 10'b0010100101; x.rd = 1'b0; x.err = 1'b0;
        q.push_back(x);
        bus.in_data = 8'h65;
        @(posedge clk);
        #1;
        x.code = 10'b1010011100; x.rd = 1'b0; x.err = 1'b0;
        q.push_back(x);
        bus.in_valid = 1'b0;
        drain();
    endtask

    task automatic test_special();
        send(8'h07, 1'b0, 10'b1110001011, 1'b1, 1'b0);
        send(8'h07, 1'b0, 10'b0001110100, 1'b0, 1'b0);
        send(8'hF7, 1'b1, 10'b1110101000, 1'b0, 1'b0);
        send(8'hFC, 1'b1, 10'b0011111000, 1'b0, 1'b0);
        send(8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
        send(8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_kcheck();
`ifdef ENC8B10B_KCHECK_EN
        send(8'h00, 1'b1, 10'b0011111010, 1'b1, 1'b1);
`else
        send(8'h00, 1'b1, 10'b1001110100, 1'b0, 1'b0);
`endif
        drain();
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
`ifdef ENC8B10B_KCHECK_EN
        send(8'hB5, 1'b0, 10'b1010101010, 1'b1, 1'b0);
`else
        send(8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
`endif
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rd !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_hold got v=%b rd=%b exp v=1 rd=1", bus.out_valid, bus.out_rd);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_rd !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got v=%b rd=%b rdy=%b exp v=0 rd=0 rdy=1",
                     bus.out_valid, bus.out_rd, bus.in_ready);
        end
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_neutral();
        test_data();
        test_stall();
        test_special();
        test_kcheck();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
